// File: rtl/fifo_tx_serializer_if.sv
// FIFO read-side handshake between the synchronous FIFO and fifo_tx_serializer.
// master = serializer (issues read strobes), slave = FIFO (supplies empty flag and data).
interface fifo_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_tx_serializer.sv
// Pops words from the FIFO and sends each as start, LSB-first data, [parity], stop on ser_out.
// Optional even-parity bit is enabled by defining TX_PARITY_EN.
module fifo_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  fifo_tx_serializer_if.master        fifo,
  output logic                        ser_out,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);

  // READ is the cycle the strobe is high; POP waits for the FIFO's registered data.
`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_POP, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_POP, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         bit_idx, bit_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next, shreg_shift;
  logic                  ser_next, rd_en, rd_next, busy_next, done_next;
  logic                  last_tick, pop_ok;
`ifdef TX_PARITY_EN
  logic                  parity, parity_next;
`endif

  assign last_tick       = (cnt == CNT_LAST);
  assign pop_ok          = en && !fifo.fifo_empty;
  assign shreg_shift     = shreg >> 1;
  assign fifo.fifo_rd_en = rd_en;

  // State and output registers; reset drops the line high and discards any captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= CNT_ZERO;
      bit_idx    <= IDX_ZERO;
      shreg      <= {DATA_WIDTH{1'b0}};
      ser_out    <= 1'b1;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      shreg      <= shreg_next;
      ser_out    <= ser_next;
      rd_en      <= rd_next;
      busy       <= busy_next;
      frame_done <= done_next;
`ifdef TX_PARITY_EN
      parity     <= parity_next;
`endif
    end
  end

  // Next-state and next-output logic; ser_next is the line level for the coming cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    ser_next   = ser_out;
    rd_next    = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
`ifdef TX_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      S_IDLE: begin
        ser_next = 1'b1;
        if (pop_ok) begin
          state_next = S_READ;
          rd_next    = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_READ: begin
        state_next = S_POP;
      end
      S_POP: begin
        shreg_next = fifo.fifo_data;
`ifdef TX_PARITY_EN
        parity_next = ^fifo.fifo_data;
`endif
        cnt_next   = CNT_ZERO;
        ser_next   = 1'b0;
        state_next = S_START;
      end
      S_START: begin
        if (last_tick) begin
          cnt_next   = CNT_ZERO;
          bit_next   = IDX_ZERO;
          ser_next   = shreg[0];
          state_next = S_DATA;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (last_tick) begin
          cnt_next   = CNT_ZERO;
          shreg_next = shreg_shift;
          if (bit_idx == IDX_LAST) begin
`ifdef TX_PARITY_EN
            ser_next   = parity;
            state_next = S_PARITY;
`else
            ser_next   = 1'b1;
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_idx + IDX_ONE;
            ser_next = shreg_shift[0];
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (last_tick) begin
          cnt_next   = CNT_ZERO;
          ser_next   = 1'b1;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        // The end of the stop bit doubles as the idle decision so pops can run back-to-back.
        if (last_tick) begin
          cnt_next = CNT_ZERO;
          ser_next = 1'b1;
          if (pop_ok) begin
            state_next = S_READ;
            rd_next    = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = CNT_ZERO;
        ser_next   = 1'b1;
      end
    endcase
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_STOP) && (cnt_next == CNT_LAST);
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed + randomized bench for fifo_tx_serializer with a FIFO model and a frame-level reference.
module tb_fifo_tx_serializer;
  localparam int DW = 8;
  localparam int BC = 4;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FC   = (DW + 2 + PAR) * BC;
  localparam int LOGN = 4096;

  logic clk = 1'b0;
  logic rst, en;
  logic ser_out, busy, frame_done;

  fifo_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_tx_serializer #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo       (bus),
    .ser_out    (ser_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: data_out is registered, valid the cycle after the read strobe.
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflow = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd_en === 1'b1) begin
      if (wr_ptr != rd_ptr) begin
        bus.fifo_data <= mem[rd_ptr % 256];
        rd_ptr        <= rd_ptr + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
  end

  logic ser_log [LOGN];
  logic rd_log  [LOGN];
  logic done_log[LOGN];
  logic busy_log[LOGN];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < LOGN) begin
      ser_log[cyc]  = ser_out;
      rd_log[cyc]   = bus.fifo_rd_en;
      done_log[cyc] = frame_done;
      busy_log[cyc] = busy;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference line level k clocks after the start-bit edge.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    int b;
    b = k / BC;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (PAR == 1 && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  // sel: 0 read strobes, 1 frame_done pulses, 2 ser_out low cycles, 3 busy cycles
  function automatic int count_log(input int sel, input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) begin
      case (sel)
        0:       n += (rd_log[i] !== 1'b0) ? 1 : 0;
        1:       n += (done_log[i] !== 1'b0) ? 1 : 0;
        2:       n += (ser_log[i] !== 1'b1) ? 1 : 0;
        default: n += (busy_log[i] !== 1'b0) ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  task automatic wait_rd(input int from, input int limit, output int p);
    int c;
    p = -1;
    c = from + 1;
    while (p < 0 && c <= from + limit) begin
      while (cyc < c) step();
      if (rd_log[c] === 1'b1) p = c;
      c++;
    end
    if (p < 0) begin
      chk("pop_timeout", 64'd0, 64'd1);
      p = from + 1;
    end
  endtask

  // Frame popped at cycle p: line, done pulse, busy and absence of extra pops over p..p+FC+1.
  task automatic check_frame(input string tag, input int p, input logic [DW-1:0] w);
    logic [63:0] so, se, dob, deb, bo, be, ro, re;
    while (cyc < p + FC + 1) step();
    so = '0; se = '0; dob = '0; deb = '0; bo = '0; be = '0; ro = '0; re = '0;
    for (int k = 0; k < FC + 2; k++) begin
      so[k]  = ser_log[p+k];
      se[k]  = (k < 2) ? 1'b1 : exp_bit(w, k - 2);
      dob[k] = done_log[p+k];
      deb[k] = (k == FC + 1);
      bo[k]  = busy_log[p+k];
      be[k]  = 1'b1;
      ro[k]  = rd_log[p+k];
      re[k]  = (k == 0);
    end
    chk({tag, "_ser"}, so, se);
    chk({tag, "_done"}, dob, deb);
    chk({tag, "_busy"}, bo, be);
    chk({tag, "_rd"}, ro, re);
  endtask

  initial begin
    int c, p, p1, p2, e;
    logic [DW-1:0] w;
    logic [DW-1:0] rw [6];

    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    chk("reset_ser", ser_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rd", bus.fifo_rd_en, 1'b0);
    chk("reset_done", frame_done, 1'b0);

    rst = 1'b0;
    en  = 1'b1;
    c = cyc;
    repeat (100) step();
    chk("empty_rd", count_log(0, c + 1, cyc), 0);
    chk("empty_ser", count_log(2, c + 1, cyc), 0);
    chk("empty_busy", count_log(3, c + 1, cyc), 0);

    push(8'hA5);
    c = cyc;
    wait_rd(c, 10, p);
    chk("a5_pop_latency", p, c + 1);
    check_frame("a5", p, 8'hA5);

    while (cyc < p + FC + 5) step();
    push(8'h00);
    push(8'hFF);
    c = cyc;
    wait_rd(c, 10, p1);
    chk("b2b_pop_latency", p1, c + 1);
    wait_rd(p1, FC + 10, p2);
    chk("b2b_spacing", p2 - p1, FC + 2);
    check_frame("b2b_00", p1, 8'h00);
    check_frame("b2b_ff", p2, 8'hFF);

    while (cyc < p2 + FC + 5) step();
    for (int i = 0; i < 6; i++) begin
      rw[i] = DW'($urandom);
      push(rw[i]);
    end
    c = cyc;
    p = c;
    for (int i = 0; i < 6; i++) begin
      p1 = p;
      wait_rd(p1, FC + 10, p);
      if (i == 0) chk("rand_pop_latency", p, c + 1);
      else        chk("rand_spacing", p - p1, FC + 2);
      check_frame("rand", p, rw[i]);
    end

    // en drops 10 clocks into the frame: frame completes, queue stalls until en returns.
    while (cyc < p + FC + 5) step();
    rw[0] = DW'($urandom);
    rw[1] = DW'($urandom);
    push(8'h3C);
    push(rw[0]);
    push(rw[1]);
    c = cyc;
    wait_rd(c, 10, p);
    while (cyc < p + 10) step();
    en = 1'b0;
    check_frame("gate_3c", p, 8'h3C);
    while (cyc < p + FC + 30) step();
    chk("gate_no_pop", count_log(0, p + 1, cyc), 0);
    e = cyc;
    en = 1'b1;
    wait_rd(e, 10, p1);
    chk("gate_resume", p1, e + 1);
    check_frame("gate_w1", p1, rw[0]);
    wait_rd(p1, FC + 10, p2);
    chk("gate_spacing", p2 - p1, FC + 2);
    check_frame("gate_w2", p2, rw[1]);

    while (cyc < p2 + FC + 5) step();
    w = DW'($urandom);
    push(w);
    c = cyc;
    wait_rd(c, 10, p);
    while (cyc < p + 15) step();
    rst = 1'b1;
    step();
    chk("midrst_ser", ser_out, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd", bus.fifo_rd_en, 1'b0);
    chk("midrst_done", frame_done, 1'b0);
    step();
    rst = 1'b0;
    c = cyc;
    repeat (60) step();
    chk("postrst_done", count_log(1, c + 1, cyc), 0);
    chk("postrst_rd", count_log(0, c + 1, cyc), 0);
    chk("postrst_ser", count_log(2, c + 1, cyc), 0);

    push(8'h01);
    c = cyc;
    wait_rd(c, 10, p);
    chk("w01_pop_latency", p, c + 1);
    check_frame("w01", p, 8'h01);
    while (cyc < p + FC + 5) step();

    chk("underflow", underflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
